// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if #(
    parameter int ADDR_W = 64
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/XOR-checksum byte stream and
// writes the payload into instruction memory, holding the core in reset.
module imem_loader #(
    parameter int MEM_SIZE = 4095,
    parameter int ADDR_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    imem_loader_if.master       bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         byte_count
);

    typedef enum logic [2:0] {
        IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [15:0] len;
    logic [15:0] cnt;
    logic [7:0]  csum;
    logic        acc;
    logic        idle_like;
    logic [15:0] n_hdr;

    assign acc        = bus.in_valid & bus.in_ready;
    assign idle_like  = (state == IDLE) | (state == DONE) | (state == ERR);
    assign n_hdr      = {len[15:8], bus.in_data};
    assign byte_count = cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_nx = HDR_HI;
            HDR_HI: if (acc) state_nx = HDR_LO;
            HDR_LO: begin
                if (acc) begin
                    if ({16'd0, n_hdr} > 32'(MEM_SIZE)) state_nx = ERR;
                    else if (n_hdr == 16'd0)            state_nx = CSUM;
                    else                                state_nx = DATA;
                end
            end
            DATA: if (acc && (cnt + 16'd1 == len)) state_nx = CSUM;
            CSUM: begin
                if (acc) state_nx = (bus.in_data == csum) ? DONE : ERR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        unique case (state)
            HDR_HI, HDR_LO, DATA, CSUM: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
            end
            DONE:    done  = 1'b1;
            ERR:     error = 1'b1;
            default: ;
        endcase
    end

    // Write port is registered so memory sees a clean one-cycle strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len           <= '0;
            cnt           <= '0;
            csum          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            if (start && idle_like) begin
                len          <= '0;
                cnt          <= '0;
                csum         <= '0;
                bus.mem_addr <= '0;
            end
            if (acc) begin
                unique case (state)
                    HDR_HI: len[15:8] <= bus.in_data;
                    HDR_LO: len[7:0]  <= bus.in_data;
                    DATA: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= ADDR_W'(cnt);
                        bus.mem_wdata <= bus.in_data;
                        cnt           <= cnt + 16'd1;
                        csum          <= csum ^ bus.in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] byte_count;

    int total = 0;
    int bad   = 0;
    logic [71:0] wq[$];

    imem_loader_if #(.ADDR_W(64)) bif ();

    imem_loader #(.MEM_SIZE(4095), .ADDR_W(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .bus        (bif),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [71:0] e;
        if (bif.mem_we === 1'b1) begin
            chk("wr_expected", 64'(wq.size() != 0), 64'd1);
            if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("wr_addr", bif.mem_addr, e[71:8]);
                chk("wr_data", 64'(bif.mem_wdata), 64'(e[7:0]));
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        n = 0;
        while (bif.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("hs_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 bif.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input logic [7:0] s[$], input int maxgap);
        int nlen;
        nlen = {s[0], s[1]};
        for (int i = 0; i < s.size(); i++) begin
            if (i >= 2 && i < 2 + nlen)
                wq.push_back({64'(i - 2), s[i]});
            send(s[i], maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
        end
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("end_timeout", 64'(n < 40), 64'd1);
    endtask

    initial begin
        logic [7:0] good[$];
        logic [7:0] badc[$];
        logic [7:0] big[$];
        logic [7:0] empty[$];
        logic [7:0] one[$];
        good  = '{8'h00, 8'h04, 8'h13, 8'h05, 8'h00, 8'h00, 8'h16};
        badc  = '{8'h00, 8'h04, 8'h13, 8'h05, 8'h00, 8'h00, 8'h17};
        big   = '{8'h10, 8'h00};
        empty = '{8'h00, 8'h00, 8'h00};
        one   = '{8'h00, 8'h01, 8'hAA, 8'hAA};
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;

        #12;
        chk("rst_ready", 64'(bif.in_ready), 64'd0);
        chk("rst_we", 64'(bif.mem_we), 64'd0);
        chk("rst_addr", bif.mem_addr, 64'd0);
        chk("rst_wdata", 64'(bif.mem_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_count", 64'(byte_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        pulse_start();
        chk("good_busy", 64'(busy), 64'd1);
        run(good, 0);
        wait_end();
        chk("good_done", 64'(done), 64'd1);
        chk("good_err", 64'(error), 64'd0);
        chk("good_count", 64'(byte_count), 64'd4);
        chk("good_ready", 64'(bif.in_ready), 64'd0);
        chk("good_q", 64'(wq.size()), 64'd0);

        pulse_start();
        chk("restart_clr", 64'(done), 64'd0);
        run(badc, 0);
        wait_end();
        chk("bad_done", 64'(done), 64'd0);
        chk("bad_err", 64'(error), 64'd1);
        chk("bad_count", 64'(byte_count), 64'd4);

        pulse_start();
        run(big, 0);
        wait_end();
        chk("big_err", 64'(error), 64'd1);
        chk("big_done", 64'(done), 64'd0);
        chk("big_ready", 64'(bif.in_ready), 64'd0);
        chk("big_count", 64'(byte_count), 64'd0);

        @(negedge clk);
        start        = 1'b1;
        bif.in_valid = 1'b1;
        bif.in_data  = 8'h05;
        @(negedge clk);
        start        = 1'b0;
        bif.in_valid = 1'b0;
        chk("ovl_busy", 64'(busy), 64'd1);
        chk("ovl_err_clr", 64'(error), 64'd0);
        run(empty, 0);
        wait_end();
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_count", 64'(byte_count), 64'd0);

        pulse_start();
        run(good, 3);
        wait_end();
        chk("bp_done", 64'(done), 64'd1);
        chk("bp_count", 64'(byte_count), 64'd4);
        chk("bp_q", 64'(wq.size()), 64'd0);

        pulse_start();
        send(8'h00, 0);
        send(8'h04, 0);
        wq.push_back({64'd0, 8'h13});
        send(8'h13, 0);
        wq.push_back({64'd1, 8'h05});
        send(8'h05, 1);
        send(8'h00, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_we", 64'(bif.mem_we), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_ready", 64'(bif.in_ready), 64'd0);
        chk("mid_count", 64'(byte_count), 64'd0);
        chk("mid_addr", bif.mem_addr, 64'd0);
        chk("mid_q", 64'(wq.size()), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        pulse_start();
        run(good, 0);
        wait_end();
        chk("rs_done1", 64'(done), 64'd1);
        pulse_start();
        chk("rs_clr", 64'(done), 64'd0);
        chk("rs_busy", 64'(busy), 64'd1);
        run(one, 0);
        wait_end();
        chk("rs_done2", 64'(done), 64'd1);
        chk("rs_count", 64'(byte_count), 64'd1);
        chk("final_q", 64'(wq.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MEM_SIZE, default 4095, number of bytes in the target instruction memory.
REQ-002 Parameter ADDR_W, default 64, width of the memory write address.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a load.
REQ-006 in_valid  input  1  a byte is present on in_data.
REQ-007 in_data  input  8  program stream byte.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 mem_we  output  1  byte write strobe to instruction memory.
REQ-010 mem_addr  output  ADDR_W  byte address of the write.
REQ-011 mem_wdata  output  8  byte to write.
REQ-012 busy  output  1  load in progress; the core is held in reset while high.
REQ-013 done  output  1  load completed with a good checksum.
REQ-014 error  output  1  load aborted, either for length or checksum.
REQ-015 byte_count  output  16  number of payload bytes written so far.

Function
REQ-016 The stream format SHALL be: length high byte, then length low byte (N, unsigned, big-endian), then N payload bytes, then 1 checksum byte.
REQ-017 The FSM states SHALL be IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE and ERR; the state is encoded as a register.
REQ-018 IDLE/DONE/ERR SHALL move to HDR_HI on start and clear done, error, byte_count, the address and the checksum.
REQ-019 start SHALL be ignored in HDR_HI, HDR_LO, DATA and CSUM.
REQ-020 A byte SHALL be accepted only in a cycle where in_valid and in_ready are both 1.
REQ-021 in_ready SHALL equal 1 exactly in HDR_HI, HDR_LO, DATA and CSUM.
REQ-022 HDR_HI SHALL latch the accepted byte as N[15:8] and move to HDR_LO.
REQ-023 HDR_LO SHALL latch N[7:0].
REQ-024 If N > MEM_SIZE, HDR_LO SHALL move to ERR.
REQ-025 If N == 0, HDR_LO SHALL move to CSUM.
REQ-026 Otherwise, HDR_LO SHALL move to DATA.
REQ-027 Payload byte i (0-based) SHALL be written to address i, so bytes land in stream order and a big-endian instruction word reads back unchanged.
REQ-028 A write SHALL be registered: mem_we is 1 for exactly one cycle, in the cycle after the accepting handshake, with mem_addr and mem_wdata valid in that same cycle.
REQ-029 mem_we SHALL be 0 in every other cycle; header and checksum bytes never produce a write.
REQ-030 byte_count SHALL increment by 1 per accepted payload byte, in the cycle after the handshake.
REQ-031 DATA SHALL move to CSUM after accepting the byte that makes the accepted count equal N.
REQ-032 The running checksum SHALL be the 8-bit XOR of all payload bytes.
REQ-033 CSUM SHALL move to DONE and set done=1 if the accepted byte equals the running checksum.
REQ-034 Otherwise, CSUM SHALL move to ERR and set error=1.
REQ-035 ERR entered on a length violation SHALL set error=1, and no payload byte is written.
REQ-036 Once set, done and error SHALL hold until the next accepted start or reset; they are never 1 simultaneously.
REQ-037 busy SHALL be 1 exactly in HDR_HI, HDR_LO, DATA and CSUM.
REQ-038 Stalls (in_valid=0) SHALL hold all state with no timeout, and addresses never wrap past N-1.
REQ-039 start and in_valid both high in IDLE SHALL not accept the byte that cycle; acceptance begins in HDR_HI.

Reset
REQ-040 While reset=0, all outputs SHALL be 0, the state SHALL be IDLE, and the length, address and checksum registers SHALL be 0.
REQ-041 Reset SHALL take effect asynchronously.
REQ-042 Reset asserted mid-load SHALL abort immediately; no further mem_we pulses occur, and the partial image is left in memory.

Verification
REQ-043 Good load: start, then stream 00 04 13 05 00 00 with checksum 16 -> 4 writes with addr 0..3 and data 13,05,00,00; then done=1, byte_count=4, busy=0.
REQ-044 Bad checksum: same stream with checksum 17 -> 4 writes, then error=1 and done=0.
REQ-045 Oversize: header 10 00 with MEM_SIZE=4095 -> error=1, zero mem_we pulses, in_ready=0 afterwards.
REQ-046 Empty load: 00 00 00 -> done=1, byte_count=0, no writes.
REQ-047 Back-pressure and reset: random in_valid gaps give writes identical to the good-load case; reset asserted after 2 payload bytes gives immediate outputs of 0, state IDLE, and no third write.
REQ-048 Restart: start in DONE followed by a second good stream of 00 01 AA AA -> done clears, then sets again, with a single write of addr 0 and data AA.
